lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store sequencing controller between the execute/memory pipeline stage and the single-port data memory. It accepts one load or store per transaction and generates the byte-lane mask and lane-aligned write data. It drives a req/gnt/rvalid handshake to the data memory and returns sign- or zero-extended load data. It stalls the pipeline for the duration of the access and rejects illegal size/offset combinations without touching memory.

## Interface
Parameters:
- DataWidth, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lsu_valid  in  1  pipeline request; sampled only when lsu_ready=1.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_fun3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 wu (loads only).
- lsu_addr  in  DataWidth  byte address.
- lsu_wdata  in  DataWidth  store data, right-justified.
- lsu_ready  out  1  controller idle; a request is accepted this cycle.
- lsu_stall  out  1  transaction in flight; pipeline must hold.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_fault  out  1  valid with lsu_done; the request was illegal and no memory access occurred.
- lsu_rdata  out  DataWidth  extended load result; valid with lsu_done and held until the next load completes.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  DataWidth  word address {addr[31:2], 2'b00}.
- mem_wmask  out  4  byte-lane write mask; bit i enables data bits [8i+7:8i].
- mem_wdata  out  DataWidth  lane-aligned write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DataWidth  raw word read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE: lsu_ready=1. On lsu_valid, latch we, fun3, addr[1:0] (off), the word address and the shifted store data.
  - Legal request → REQ.
  - Illegal request → FAULT.
- Legality:
  - Byte: any off.
  - Half: off ≠ 3.
  - Word (010, 110): off = 0.
  - Stores: fun3 ∈ {000, 001, 010} only.
  - Loads: fun3 ∈ {000, 001, 010, 100, 101, 110}.
  - Anything else is illegal.
- Store mask = base << off, with base 0001 (b), 0011 (h), 1111 (w). mem_wdata = lsu_wdata << (8·off). Unmasked lanes are don't-care.
- REQ: mem_req=1. mem_we, mem_addr, mem_wmask and mem_wdata stay stable until mem_gnt.
  - Store with gnt → DONE.
  - Load with gnt → WAIT.
  - No gnt → stay in REQ.
  - mem_rvalid is ignored in REQ.
- WAIT: mem_req=0. On mem_rvalid, compute sh = mem_rdata >> (8·off), then extend:
  - b: sign-extend sh[7:0].
  - h: sign-extend sh[15:0].
  - bu: zero-extend sh[7:0].
  - hu: zero-extend sh[15:0].
  - w / wu: no extension.
  - Register the result into lsu_rdata → DONE.
- DONE: lsu_done=1 → IDLE.
- FAULT: lsu_done=1, lsu_fault=1, mem_req=0 → IDLE.
- lsu_stall=1 in REQ, WAIT, DONE and FAULT. lsu_ready is the exact complement of lsu_stall.
- lsu_valid is ignored outside IDLE. mem_rvalid is ignored outside WAIT.

## Timing
- All outputs are registered or a pure decode of the state register.
- Reset values: state IDLE, lsu_ready=1, all other outputs 0 (including lsu_rdata, mem_addr, mem_wmask, mem_wdata).
- Store, immediate grant: accept at t0, REQ at t1 with gnt, lsu_done at t2. Total 3 cycles.
- Load, immediate grant and next-cycle rvalid: accept at t0, REQ at t1, WAIT at t2 with rvalid, DONE with lsu_rdata at t3.
- Each gnt stall cycle extends REQ by one cycle. Each rvalid delay cycle extends WAIT by one cycle. There is no timeout.
- Fault: accept at t0, lsu_done with lsu_fault at t1. mem_req is never asserted.
- Back-to-back: the next request is accepted in the cycle after DONE (IDLE).
- Reset mid-transaction: mem_req and lsu_stall drop asynchronously. A late mem_rvalid after reset is ignored. lsu_rdata clears to 0.
- A store never modifies lsu_rdata.

## Test plan
- Reset asserted during REQ with mem_gnt held low → mem_req=0 immediately, lsu_ready=1, lsu_rdata=0; a mem_rvalid arriving afterwards has no effect.
- Store sb: addr 0x1001, wdata 0x000000AB, gnt at first REQ cycle → mem_addr 0x1000, mem_wmask 0010, mem_wdata[15:8]=0xAB, lsu_done 2 cycles after accept.
- Load lh, addr 0x2002, mem_rdata 0x8001_1234, gnt delayed 2 cycles, rvalid 1 cycle after gnt → lsu_rdata 0xFFFF8001; load lhu at the same address → 0x00008001.
- Load lb at offsets 0–3 with mem_rdata 0x80_7F_01_FF → lsu_rdata sequence 0xFFFFFFFF, 0x00000001, 0x0000007F, 0xFFFFFF80.
- Illegal requests: lw at addr 0x3002, sh at offset 3, store with fun3 100 → each gives lsu_done=lsu_fault=1 one cycle after accept; mem_req stays 0 throughout.
- Back-to-back sw 0x4000 (wdata 0xDEADBEEF, mask 1111) then lw 0x4000 returning 0xDEADBEEF → second request accepted the cycle after the first lsu_done; lsu_rdata 0xDEADBEEF.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store sequencing controller sitting between the execute/memory pipeline
// stage and a single-port data memory. One load or store is handled per
// transaction. The controller:
//   - checks the size/offset combination and faults illegal requests without
//     touching memory,
//   - builds the byte-lane write mask and lane-aligned store data,
//   - runs a req/gnt/rvalid handshake to the memory,
//   - returns sign- or zero-extended load data.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   lsu_valid          pipeline request, only looked at while lsu_ready=1
//   lsu_we             1 = store, 0 = load
//   lsu_fun3           RV32 funct3 (b/h/w/bu/hu/wu)
//   lsu_addr           byte address
//   lsu_wdata          right-justified store data
//   lsu_ready          controller idle, request accepted this cycle
//   lsu_stall          transaction in flight (complement of lsu_ready)
//   lsu_done           one-cycle completion pulse
//   lsu_fault          with lsu_done: request was illegal, memory untouched
//   lsu_rdata          extended load result, held until the next load completes
//   mem_req            memory request
//   mem_we             memory write enable
//   mem_addr           word-aligned address
//   mem_wmask          byte-lane write mask
//   mem_wdata          lane-aligned write data
//   mem_gnt            memory accepted the request
//   mem_rvalid         memory read data valid
//   mem_rdata          raw memory read word
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_valid,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_fun3,
  input  logic [DataWidth-1:0] lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  output logic                 lsu_ready,
  output logic                 lsu_stall,
  output logic                 lsu_done,
  output logic                 lsu_fault,
  output logic [DataWidth-1:0] lsu_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DataWidth-1:0] mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t         state_r;
  logic           we_r;
  logic [2:0]     fun3_r;
  logic [1:0]     off_r;
  logic [31:0]    addr_r;
  logic [3:0]     wmask_r;
  logic [31:0]    wdata_r;
  logic [31:0]    rdata_r;

  // Legal size/offset/direction combinations. Halfwords may straddle lanes
  // inside the word but never the word boundary.
  function automatic logic is_legal(input logic we, input logic [2:0] fun3,
                                    input logic [1:0] off);
    logic ok;
    case (fun3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off != 2'd3);
      3'b010:  ok = (off == 2'd0);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & (off != 2'd3);
      3'b110:  ok = ~we & (off == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane mask for a store; loads carry an empty mask.
  function automatic logic [3:0] store_mask(input logic we, input logic [2:0] fun3,
                                            input logic [1:0] off);
    logic [3:0] base;
    case (fun3)
      3'b000:  base = 4'b0001;
      3'b001:  base = 4'b0011;
      3'b010:  base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return we ? (base << off) : 4'b0000;
  endfunction

  // Lane-align the raw read word and extend according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] fun3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (fun3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Transaction FSM together with the latched request fields and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      fun3_r  <= 3'b000;
      off_r   <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wmask_r <= 4'b0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (lsu_valid) begin
            we_r    <= lsu_we;
            fun3_r  <= lsu_fun3;
            off_r   <= lsu_addr[1:0];
            addr_r  <= {lsu_addr[31:2], 2'b00};
            wmask_r <= store_mask(lsu_we, lsu_fun3, lsu_addr[1:0]);
            wdata_r <= lsu_wdata << {lsu_addr[1:0], 3'b000};
            state_r <= is_legal(lsu_we, lsu_fun3, lsu_addr[1:0]) ? REQ : FAULT;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state_r <= we_r ? DONE : WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_r <= load_extend(fun3_r, off_r, mem_rdata);
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE:    state_r <= IDLE;
        FAULT:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register directly so reset drops them
  // asynchronously.
  assign lsu_ready = (state_r == IDLE);
  assign lsu_stall = (state_r != IDLE);
  assign lsu_done  = (state_r == DONE) || (state_r == FAULT);
  assign lsu_fault = (state_r == FAULT);
  assign mem_req   = (state_r == REQ);
  assign mem_we    = (state_r == REQ) & we_r;
  assign mem_addr  = addr_r;
  assign mem_wmask = wmask_r;
  assign mem_wdata = wdata_r;
  assign lsu_rdata = rdata_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Directed and randomized transactions against lsu_mem_ctrl. Expected values
// come from a size/offset arithmetic model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_fun3 = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic        lsu_ready, lsu_stall, lsu_done, lsu_fault;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = 32'h0;

  lsu_mem_ctrl #(.DataWidth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_fun3(lsu_fun3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .lsu_fault(lsu_fault), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3; 0 marks an unsupported encoding.
  function automatic int ref_size(input logic [2:0] f3);
    int s;
    s = 0;
    if (f3[1:0] == 2'd0) s = 1;
    if (f3[1:0] == 2'd1) s = 2;
    if (f3[1:0] == 2'd2) s = 4;
    return s;
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input int off);
    int s;
    s = ref_size(f3);
    if (s == 0) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (off + s) <= 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] word);
    longint v;
    longint span;
    logic [31:0] r;
    int s;
    s = ref_size(f3);
    span = longint'(1) << (8 * s);
    v = (longint'(word) / (longint'(1) << (8 * off))) % span;
    if (!f3[2] && s < 4 && v >= span / 2) v = v - span;
    r = v[31:0];
    return r;
  endfunction

  // One full transaction: gd = grant stall cycles, rd = rvalid delay cycles.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rword,
                     input int gd, input int rd);
    int          off;
    int          s;
    bit          legal;
    logic [3:0]  emask;
    logic [31:0] lanes;
    logic [31:0] ewdata;
    off   = int'(addr[1:0]);
    s     = ref_size(f3);
    legal = ref_legal(we, f3, off);
    emask = 4'b0000;
    lanes = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + s) begin
        emask[i] = 1'b1;
        lanes[8*i +: 8] = 8'hFF;
      end
    end
    ewdata = (wdata * (32'd1 << (8 * off))) & lanes;

    @(negedge clk);
    chk("ready_idle", {31'b0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1; lsu_we = we; lsu_fun3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    @(negedge clk);
    lsu_valid = $urandom_range(0, 1); lsu_we = ~we; lsu_fun3 = 3'($urandom);
    lsu_addr = $urandom; lsu_wdata = $urandom;
    chk("stall_t1", {31'b0, lsu_stall}, 32'd1);
    if (!legal) begin
      chk("fault_done", {30'b0, lsu_done, lsu_fault}, 32'd3);
      chk("fault_noreq", {31'b0, mem_req}, 32'd0);
      lsu_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req", {31'b0, mem_req}, 32'd1);
      chk("req_done", {31'b0, lsu_done}, 32'd0);
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      if (we) begin
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, emask});
        chk("mem_wdata", mem_wdata & lanes, ewdata);
      end
      mem_gnt    = (i == gd);
      mem_rvalid = $urandom_range(0, 1);
      mem_rdata  = $urandom;
      @(negedge clk);
      lsu_valid  = 1'b0;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!we) begin
      for (int i = 0; i < rd; i++) begin
        chk("wait", {29'b0, mem_req, lsu_done, lsu_stall}, 32'd1);
        @(negedge clk);
      end
      chk("wait_last", {29'b0, mem_req, lsu_done, lsu_stall}, 32'd1);
      mem_rvalid = 1'b1; mem_rdata = rword;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      exp_rdata = ref_load(f3, off, rword);
    end
    chk("done", {30'b0, lsu_done, lsu_fault}, 32'd2);
    chk("done_noreq", {31'b0, mem_req}, 32'd0);
    chk("rdata", lsu_rdata, exp_rdata);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_ready", {31'b0, lsu_ready}, 32'd1);
    chk("rst_flags", {27'b0, lsu_stall, lsu_done, lsu_fault, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    txn(1'b1, 3'b000, 32'h0000_1001, 32'h0000_00AB, 32'h0, 0, 0);
    txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 0);
    chk("lh", lsu_rdata, 32'hFFFF_8001);
    txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
    chk("lhu", lsu_rdata, 32'h0000_8001);
    txn(1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h807F_01FF, 0, 0);
    chk("lb0", lsu_rdata, 32'hFFFF_FFFF);
    txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h807F_01FF, 0, 1);
    chk("lb1", lsu_rdata, 32'h0000_0001);
    txn(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h807F_01FF, 1, 0);
    chk("lb2", lsu_rdata, 32'h0000_007F);
    txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h807F_01FF, 0, 2);
    chk("lb3", lsu_rdata, 32'hFFFF_FF80);
    txn(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, 0);
    txn(1'b1, 3'b001, 32'h0000_3003, 32'h1234_5678, 32'h0, 0, 0);
    txn(1'b1, 3'b100, 32'h0000_3000, 32'h1234_5678, 32'h0, 0, 0);
    chk("fault_keeps_rdata", lsu_rdata, 32'hFFFF_FF80);
    txn(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 0, 0);
    txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    chk("lw_b2b", lsu_rdata, 32'hDEAD_BEEF);

    // Reset while stuck in REQ with no grant
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_fun3 = 3'b010; lsu_addr = 32'h0000_5000;
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("rstm_req", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_noreq", {31'b0, mem_req}, 32'd0);
    chk("rstm_ready", {30'b0, lsu_ready, lsu_stall}, 32'd2);
    chk("rstm_rdata", lsu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid", {29'b0, lsu_ready, lsu_done, mem_req}, 32'd4);
    chk("late_rdata", lsu_rdata, 32'd0);
    exp_rdata = 32'h0;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("final_idle", {31'b0, lsu_ready}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
